ac97_frame_tx: RTL and testbench
================================

# ac97_frame_tx

Serial AC'97 link transmitter for the synthesizer. It runs on the codec's BIT_CLK and builds the 256-bit output frame: SYNC, the slot-0 tag, command slots 1–2, and 18-bit left/right PCM in slots 3–4. It serializes the frame onto SDATA_OUT. It also generates the one-cycle-per-frame frame_sig strobe that paces the wave generators, and it consumes their 18-bit samples.

## Interface
- No parameters. The frame length of 256 bits and the 18-bit sample width are fixed.
- BIT_CLK  in  1  codec bit clock, 12.288 MHz; the only clock.
- RESET  in  1  synchronous, active-high reset.
- PCM_L  in  18  left sample, two's complement, MSB first on the link.
- PCM_R  in  18  right sample.
- CMD_VALID  in  1  codec register command offered.
- CMD_RW  in  1  1 = read, 0 = write.
- CMD_ADDR  in  7  codec register address.
- CMD_DATA  in  16  write data; ignored for reads.
- CMD_READY  out  1  the one-deep command holding register is empty.
- SYNC  out  1  AC'97 frame sync.
- SDATA_OUT  out  1  serial frame data.
- frame_sig  out  1  one-cycle strobe at the start of each frame.

## Operation
- Bit counter BIT_COUNT runs 0..255 and wraps 255→0 with no gap.
- All outputs are registered. At each posedge the outputs present frame bit k = BIT_COUNT, then the counter advances.
- "Frame bit k" below always means the output cycle.
- Frame layout, MSB first within each slot:
  - slot 0: bits 0–15
  - slot 1: bits 16–35
  - slot 2: bits 36–55
  - slot 3: bits 56–75
  - slot 4: bits 76–95
  - slots 5–12: bits 96–255, all 0
- Slot 0 tag, as bits 15..0:
  - 1, then CV, then CV&~RW, then 1, then 1, then eleven 0s.
  - CV = the holding register was full at the frame snapshot.
- Slot 1: RW, ADDR[6:0], then twelve 0s. All zero if CV=0.
- Slot 2: DATA[15:0], then four 0s. All zero if CV=0 or RW=1.
- Slot 3: PCM_L[17:0], then two 0s. Slot 4: PCM_R[17:0], then two 0s.
- Frame snapshot:
  - Taken at the edge that outputs frame bit 0.
  - Captures PCM_L, PCM_R and the holding-register state, including the full flag, as they stand before that edge.
  - The whole frame is built from the snapshot. Input changes mid-frame do not affect the current frame.
- Command handshake:
  - A command is accepted on an edge where CMD_VALID and CMD_READY are both high.
  - On acceptance the holding register loads RW, ADDR and DATA, and CMD_READY drops the next cycle.
  - The holding register is released at the edge that outputs frame bit 55, but only if CV=1 for that frame. CMD_READY returns high on that same edge.
  - A command accepted on the bit-0 snapshot edge is not in that frame; it goes in the next frame.
- SYNC is 1 on frame bits 0–15 and 0 on bits 16–255.
- frame_sig is 1 only on frame bit 0.

## Timing
- Reset, while RESET is sampled high:
  - BIT_COUNT = 0, holding register emptied, snapshot cleared to zero.
  - SYNC = 0, SDATA_OUT = 0, frame_sig = 0, CMD_READY = 0.
- First edge with RESET low outputs frame bit 0:
  - SYNC = 1, frame_sig = 1, SDATA_OUT = 1.
  - CMD_READY = 1 from that edge.
- Reset asserted mid-frame aborts the frame immediately. Outputs go to reset values on the next edge, and any held command is lost.
- Period: frame_sig repeats every 256 cycles exactly. SYNC rises every 256 cycles and stays high for 16 cycles.
- Sample latency: PCM value present before snapshot edge N → first PCM bit at frame bit 56, i.e. 56 cycles after frame_sig.
- Command latency:
  - Worst case: 256 + 55 cycles from acceptance to release.
  - Minimum: 55 cycles from the snapshot.
- CMD_VALID held high with CMD_READY low has no effect. The requester holds its payload stable until acceptance.

## Test plan
- Reset then idle, PCM_L = 18'h3FFFF, PCM_R = 0:
  - frame_sig every 256 cycles; SYNC high for 16 cycles.
  - Tag = 16'b1001_1000_0000_0000.
  - Bits 56–73 all 1, bits 74–95 all 0, bits 96–255 all 0.
- Write command ADDR = 7'h02, DATA = 16'h8000, accepted mid-frame:
  - Next frame tag = 16'hF800.
  - Slot 1 = 20'h02000, slot 2 = 20'h80000.
  - CMD_READY returns high on frame bit 55; the following frame's tag = 16'h9800.
- Read command ADDR = 7'h26:
  - Tag = 16'hD800, slot 1 = 20'hA6000, slot 2 = 0.
- Command accepted exactly on the bit-0 edge:
  - Absent from that frame (tag 16'h9800).
  - Present in the next frame.
- PCM_L changed from 18'h20000 to 18'h00001 at frame bit 60:
  - Current slot 3 still = 18'h20000.
  - Next frame's slot 3 = 18'h00001.
- RESET pulsed for one cycle at frame bit 130 with a held command:
  - Outputs go to 0, and CMD_READY drops to 0 during reset.
  - Restart at bit 0 with tag 16'h9800; the held command is discarded.

Source files
------------

// File: rtl/ac97_frame_tx.sv
// AC'97 serial frame transmitter. Builds the 256-bit output frame from a
// per-frame snapshot: SYNC, the slot-0 tag, command slots 1-2 and the PCM
// slots 3-4. It drives SDATA_OUT, SYNC, the frame_sig pacing strobe and a
// one-deep command holding register with a valid/ready handshake.
module ac97_frame_tx (
    input  logic        BIT_CLK,
    input  logic        RESET,
    input  logic [17:0] PCM_L,
    input  logic [17:0] PCM_R,
    input  logic        CMD_VALID,
    input  logic        CMD_RW,
    input  logic [6:0]  CMD_ADDR,
    input  logic [15:0] CMD_DATA,
    output logic        CMD_READY,
    output logic        SYNC,
    output logic        SDATA_OUT,
    output logic        frame_sig
);

    // Frame bit that the next edge will present on the outputs.
    logic [7:0]  bit_cnt_q, bit_cnt_d;

    // One-deep command holding register.
    logic        hold_full_q, hold_full_d;
    logic        hold_rw_q, hold_rw_d;
    logic [6:0]  hold_addr_q, hold_addr_d;
    logic [15:0] hold_data_q, hold_data_d;

    // Per-frame snapshot; the whole frame is built from these.
    logic        snap_cv_q;
    logic        snap_rw_q;
    logic [6:0]  snap_addr_q;
    logic [15:0] snap_data_q;
    logic [17:0] snap_l_q;
    logic [17:0] snap_r_q;

    // Registered outputs.
    logic        ready_q, ready_d;
    logic        sync_q, sync_d;
    logic        sdata_q, sdata_d;
    logic        fsig_q, fsig_d;

    logic        accept;
    logic        release_cmd;
    logic        slot2_en;
    logic [6:0]  vec_idx;
    logic [95:0] frame_vec;

    // Next-state logic: counter, handshake, and the serial bit for this edge.
    always_comb begin
        bit_cnt_d   = bit_cnt_q + 8'd1;
        accept      = CMD_VALID & ready_q;
        release_cmd = snap_cv_q & (bit_cnt_q == 8'd55);

        hold_full_d = hold_full_q;
        hold_rw_d   = hold_rw_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        // Release and accept can never coincide: accept needs an empty
        // register, release needs a full one.
        if (release_cmd) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_rw_d   = CMD_RW;
            hold_addr_d = CMD_ADDR;
            hold_data_d = CMD_DATA;
        end
        ready_d = ~hold_full_d;

        // Frame bits 0..95, frame bit k lives at index 95-k; bits 96..255 are 0.
        // Bit 0 (tag MSB) is constant 1, so the snapshot taken on that same
        // edge never needs to be visible yet.
        slot2_en  = snap_cv_q & ~snap_rw_q;
        frame_vec = {1'b1, snap_cv_q, slot2_en, 1'b1, 1'b1, 11'd0,
                     snap_cv_q & snap_rw_q, snap_addr_q & {7{snap_cv_q}}, 12'd0,
                     snap_data_q & {16{slot2_en}}, 4'd0,
                     snap_l_q, 2'd0,
                     snap_r_q, 2'd0};
        vec_idx   = 7'd95 - bit_cnt_q[6:0];
        sdata_d   = 1'b0;
        if (bit_cnt_q < 8'd96) begin
            sdata_d = frame_vec[vec_idx];
        end

        sync_d = (bit_cnt_q < 8'd16);
        fsig_d = (bit_cnt_q == 8'd0);
    end

    // State and output registers, with the frame snapshot on the bit-0 edge.
    always_ff @(posedge BIT_CLK) begin
        if (RESET) begin
            bit_cnt_q   <= 8'd0;
            hold_full_q <= 1'b0;
            hold_rw_q   <= 1'b0;
            hold_addr_q <= 7'd0;
            hold_data_q <= 16'd0;
            snap_cv_q   <= 1'b0;
            snap_rw_q   <= 1'b0;
            snap_addr_q <= 7'd0;
            snap_data_q <= 16'd0;
            snap_l_q    <= 18'd0;
            snap_r_q    <= 18'd0;
            ready_q     <= 1'b0;
            sync_q      <= 1'b0;
            sdata_q     <= 1'b0;
            fsig_q      <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            hold_full_q <= hold_full_d;
            hold_rw_q   <= hold_rw_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            if (bit_cnt_q == 8'd0) begin
                // Pre-edge view: a command accepted on this edge is not seen.
                snap_cv_q   <= hold_full_q;
                snap_rw_q   <= hold_rw_q;
                snap_addr_q <= hold_addr_q;
                snap_data_q <= hold_data_q;
                snap_l_q    <= PCM_L;
                snap_r_q    <= PCM_R;
            end
            ready_q <= ready_d;
            sync_q  <= sync_d;
            sdata_q <= sdata_d;
            fsig_q  <= fsig_d;
        end
    end

    assign CMD_READY = ready_q;
    assign SYNC      = sync_q;
    assign SDATA_OUT = sdata_q;
    assign frame_sig = fsig_q;

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Directed bench for ac97_frame_tx: a monitor records each serial frame,
// the initial block drives directed steps and checks hand-computed values.
module tb_ac97_frame_tx;

    logic        BIT_CLK = 1'b0;
    logic        RESET;
    logic [17:0] PCM_L;
    logic [17:0] PCM_R;
    logic        CMD_VALID;
    logic        CMD_RW;
    logic [6:0]  CMD_ADDR;
    logic [15:0] CMD_DATA;
    logic        CMD_READY;
    logic        SYNC;
    logic        SDATA_OUT;
    logic        frame_sig;

    int n_assert = 0;
    int n_fail   = 0;

    ac97_frame_tx dut (
        .BIT_CLK   (BIT_CLK),
        .RESET     (RESET),
        .PCM_L     (PCM_L),
        .PCM_R     (PCM_R),
        .CMD_VALID (CMD_VALID),
        .CMD_RW    (CMD_RW),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_DATA  (CMD_DATA),
        .CMD_READY (CMD_READY),
        .SYNC      (SYNC),
        .SDATA_OUT (SDATA_OUT),
        .frame_sig (frame_sig)
    );

    always #5 BIT_CLK = ~BIT_CLK;

    // Monitor: position within the frame, recorded frames, period, SYNC width.
    int           pos     = -1;
    int           fcnt    = 0;
    int           cyc     = 0;
    int           last_fs = -1;
    int           period  = 0;
    int           run     = 0;
    int           sync_len = 0;
    logic [0:255] cur_fr;
    logic [0:255] last_fr;

    always @(posedge BIT_CLK) begin
        #1;
        cyc++;
        if (frame_sig) begin
            if (last_fs >= 0) period = cyc - last_fs;
            last_fs = cyc;
            pos = 0;
        end else if (pos >= 0) begin
            pos++;
        end
        if (pos >= 0 && pos < 256) cur_fr[pos] = SDATA_OUT;
        if (pos == 255) begin
            last_fr = cur_fr;
            fcnt++;
        end
        if (SYNC) run++;
        else if (run > 0) begin
            sync_len = run;
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
        $display("check %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Step negedges until the monitor reports frame position n (bounded).
    task automatic wait_pos(input int n);
        bit ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge BIT_CLK);
            if (pos == n) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_assert++;
            n_fail++;
            $display("FAIL wait_pos: position %0d never reached", n);
        end
    endtask

    // Step until the next frame has been fully recorded (bounded).
    task automatic wait_frame();
        int start = fcnt;
        bit ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge BIT_CLK);
            if (fcnt != start) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_assert++;
            n_fail++;
            $display("FAIL wait_frame: no complete frame");
        end
    endtask

    // Offer one command at a negedge; it is taken on the next edge.
    task automatic offer(input logic rw, input logic [6:0] addr, input logic [15:0] data);
        CMD_VALID = 1'b1;
        CMD_RW    = rw;
        CMD_ADDR  = addr;
        CMD_DATA  = data;
        @(negedge BIT_CLK);
        CMD_VALID = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        PCM_L = 18'h3FFFF;
        PCM_R = 18'h0;
        CMD_VALID = 1'b0;
        CMD_RW = 1'b0;
        CMD_ADDR = 7'h0;
        CMD_DATA = 16'h0;

        // Reset state
        repeat (3) @(negedge BIT_CLK);
        chk("rst_sync", 32'(SYNC), 32'h0);
        chk("rst_sdata", 32'(SDATA_OUT), 32'h0);
        chk("rst_fsig", 32'(frame_sig), 32'h0);
        chk("rst_ready", 32'(CMD_READY), 32'h0);

        // First edge out of reset presents frame bit 0
        RESET = 1'b0;
        @(negedge BIT_CLK);
        chk("bit0_sync", 32'(SYNC), 32'h1);
        chk("bit0_fsig", 32'(frame_sig), 32'h1);
        chk("bit0_sdata", 32'(SDATA_OUT), 32'h1);
        chk("bit0_ready", 32'(CMD_READY), 32'h1);

        // Idle frame
        wait_frame();
        chk("idle_tag", 32'(last_fr[0:15]), 32'h9800);
        chk("idle_slot3", 32'(last_fr[56:73]), 32'h3FFFF);
        chk("idle_74_95", 32'(last_fr[74:95]), 32'h0);
        chk("idle_96_255", 32'(last_fr[96:255] == 160'd0), 32'h1);
        repeat (2) @(negedge BIT_CLK);
        chk("fsig_period", 32'(period), 32'd256);
        chk("sync_width", 32'(sync_len), 32'd16);

        // Write command mid-frame
        wait_pos(100);
        offer(1'b0, 7'h02, 16'h8000);
        chk("wr_ready_drop", 32'(CMD_READY), 32'h0);
        wait_frame();
        chk("wr_cur_tag", 32'(last_fr[0:15]), 32'h9800);
        wait_pos(54);
        chk("wr_ready_b54", 32'(CMD_READY), 32'h0);
        wait_pos(55);
        chk("wr_ready_b55", 32'(CMD_READY), 32'h1);
        wait_frame();
        chk("wr_tag", 32'(last_fr[0:15]), 32'hF800);
        chk("wr_slot1", 32'(last_fr[16:35]), 32'h02000);
        chk("wr_slot2", 32'(last_fr[36:55]), 32'h80000);
        wait_frame();
        chk("wr_after_tag", 32'(last_fr[0:15]), 32'h9800);

        // Read command
        wait_pos(100);
        offer(1'b1, 7'h26, 16'hFFFF);
        wait_frame();
        wait_frame();
        chk("rd_tag", 32'(last_fr[0:15]), 32'hD800);
        chk("rd_slot1", 32'(last_fr[16:35]), 32'hA6000);
        chk("rd_slot2", 32'(last_fr[36:55]), 32'h0);

        // Command accepted on the bit-0 snapshot edge
        wait_pos(255);
        offer(1'b0, 7'h10, 16'h1234);
        chk("b0_fsig", 32'(frame_sig), 32'h1);
        chk("b0_ready_drop", 32'(CMD_READY), 32'h0);
        wait_frame();
        chk("b0_tag_absent", 32'(last_fr[0:15]), 32'h9800);
        wait_frame();
        chk("b0_tag_next", 32'(last_fr[0:15]), 32'hF800);
        chk("b0_slot1", 32'(last_fr[16:35]), 32'h10000);
        chk("b0_slot2", 32'(last_fr[36:55]), 32'h12340);

        // PCM_L change mid-frame (monitor is at bit 255 here)
        PCM_L = 18'h20000;
        wait_pos(60);
        PCM_L = 18'h00001;
        wait_frame();
        chk("pcm_cur_slot3", 32'(last_fr[56:73]), 32'h20000);
        wait_frame();
        chk("pcm_next_slot3", 32'(last_fr[56:73]), 32'h00001);

        // Reset mid-frame with a held command
        wait_pos(100);
        offer(1'b0, 7'h05, 16'hABCD);
        wait_pos(130);
        RESET = 1'b1;
        @(negedge BIT_CLK);
        chk("mid_rst_sync", 32'(SYNC), 32'h0);
        chk("mid_rst_sdata", 32'(SDATA_OUT), 32'h0);
        chk("mid_rst_fsig", 32'(frame_sig), 32'h0);
        chk("mid_rst_ready", 32'(CMD_READY), 32'h0);
        RESET = 1'b0;
        @(negedge BIT_CLK);
        chk("restart_fsig", 32'(frame_sig), 32'h1);
        chk("restart_ready", 32'(CMD_READY), 32'h1);
        wait_frame();
        chk("restart_tag", 32'(last_fr[0:15]), 32'h9800);
        chk("restart_slot1", 32'(last_fr[16:35]), 32'h0);
        wait_frame();
        chk("restart_tag2", 32'(last_fr[0:15]), 32'h9800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
